// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin packet arbiter merging N AXI-Stream sources into one registered output.
// Define AXIS_ARB_TID_EN to add the m_tid output carrying the source index of each beat.
module axis_rr_arbiter #(
  parameter int dw = 8,
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N*dw-1:0] s_tdata,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N-1:0]    s_tlast,
  output logic [N-1:0]    s_tready,
  output logic [dw-1:0]   m_tdata,
  output logic            m_tvalid,
  output logic            m_tlast,
  input  logic            m_tready,
  output logic [N-1:0]    grant,
  output logic            busy
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [IW-1:0]   m_tid
`endif
);
  typedef enum logic {IDLE, PASS} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] own_q, own_d, win, c;
  logic [dw-1:0] tdata_q, tdata_d, sel_data;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic room, acc, last_beat, found;
  // own_q is the current owner in PASS and doubles as the previous owner in IDLE
  always_comb begin
    win = own_q;
    found = 1'b0;
    c = own_q;
    for (int k = 1; k <= N; k++) begin
      c = IW'((int'(own_q) + k) % N);
      if (!found && s_tvalid[c]) begin
        win = c;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    grant = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = state_q == PASS && own_q == IW'(i);
      if (own_q == IW'(i)) sel_data = s_tdata[i*dw +: dw];
    end
  end
  assign room = !tvalid_q || m_tready;
  assign s_tready = room ? grant : '0;
  assign acc = |(s_tvalid & s_tready);
  assign last_beat = |(s_tlast & grant);
  assign busy = state_q == PASS;
  assign m_tdata = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast = tlast_q;
  always_comb begin
    state_d = state_q == IDLE ? (|s_tvalid ? PASS : IDLE) : (acc && last_beat ? IDLE : PASS);
    own_d = state_q == IDLE && |s_tvalid ? win : own_q;
    tdata_d = acc ? sel_data : tdata_q;
    tlast_d = acc ? last_beat : tlast_q;
    tvalid_d = acc || (tvalid_q && !m_tready);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      own_q <= IW'(N-1);
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
    end
  end
`ifdef AXIS_ARB_TID_EN
  logic [IW-1:0] tid_q;
  assign m_tid = tid_q;
  always_ff @(posedge clk) begin
    if (!rstn) tid_q <= '0;
    else if (acc) tid_q <= own_q;
  end
`endif
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed + randomized bench with a queue-based reference model of the arbiter.
module tb_axis_rr_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int IW = $clog2(N);
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0] s_tvalid, s_tlast, s_tready, grant;
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tlast, m_tready, busy;
`ifdef AXIS_ARB_TID_EN
  logic [IW-1:0] m_tid;
  int ot;
`endif
  int tests = 0, fails = 0;
  int nin = 0, nout = 0;
  logic [DW:0] srcq [N][$];
  int stall [N];
  logic [7:0] order [$];
  bit busy_m, ov, ol;
  int own;
  logic [7:0] od;
  always #5 clk = ~clk;
  axis_rr_arbiter #(.dw(DW), .N(N)) dut (
    .clk(clk), .rstn(rstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .grant(grant), .busy(busy)
`ifdef AXIS_ARB_TID_EN
    , .m_tid(m_tid)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // next owner: first requester scanning upward with wrap from the previous owner
  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction
  function automatic bit pending();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic push_pkt(input int src, input int len, input logic [7:0] base, input bit rnd);
    for (int j = 0; j < len; j++) srcq[src].push_back({j == len - 1, rnd ? 8'($urandom) : base});
  endtask
  task automatic drive();
    logic [DW:0] b;
    for (int i = 0; i < N; i++) begin
      b = srcq[i].size() != 0 ? srcq[i][0] : '0;
      s_tvalid[i] = srcq[i].size() != 0 && stall[i] == 0;
      s_tdata[i*DW +: DW] = b[DW-1:0];
      s_tlast[i] = b[DW];
    end
  endtask
  task automatic cycle();
    logic [N-1:0] eg;
    logic [DW:0] b;
    bit acc, fo;
    @(negedge clk);
    eg = '0;
    if (busy_m) eg[own] = 1'b1;
    chk("grant", grant, eg);
    chk("busy", busy, busy_m);
    chk("s_tready", s_tready, (busy_m && (!ov || m_tready)) ? eg : '0);
    chk("m_tvalid", m_tvalid, ov);
    chk("m_tdata", m_tdata, od);
    chk("m_tlast", m_tlast, ol);
`ifdef AXIS_ARB_TID_EN
    chk("m_tid", m_tid, ot);
`endif
    acc = busy_m && s_tvalid[own] && (!ov || m_tready);
    fo = ov && m_tready;
    if (m_tvalid && m_tready) begin
      nout++;
      if (m_tlast) order.push_back(m_tdata);
    end
    @(posedge clk);
    if (!rstn) begin
      busy_m = 0; own = N - 1; ov = 0; od = '0; ol = 0;
`ifdef AXIS_ARB_TID_EN
      ot = 0;
`endif
    end else begin
      if (fo) ov = 0;
      if (!busy_m) begin
        if (|s_tvalid) begin
          own = pick(own, s_tvalid);
          busy_m = 1;
        end
      end else if (acc) begin
        b = srcq[own].pop_front();
        nin++;
        ov = 1; od = b[DW-1:0]; ol = b[DW];
`ifdef AXIS_ARB_TID_EN
        ot = own;
`endif
        if (b[DW]) busy_m = 0;
      end
    end
    #1;
    for (int i = 0; i < N; i++) if (stall[i] > 0) stall[i]--;
    drive();
  endtask
  task automatic run(input int max, output int c);
    c = 0;
    while ((pending() || ov || busy_m) && c < max) begin
      cycle();
      c++;
    end
    chk("drain_bound", c < max, 1);
  endtask
  task automatic do_reset();
    rstn = 0;
    cycle();
    cycle();
    rstn = 1;
  endtask
  initial begin
    int c, n0;
    logic [DW:0] b;
    logic [7:0] fd;
    logic [7:0] rot_exp [5];
    rot_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    m_tready = 1;
    for (int i = 0; i < N; i++) stall[i] = 0;
    busy_m = 0; own = N - 1; ov = 0; od = '0; ol = 0;
`ifdef AXIS_ARB_TID_EN
    ot = 0;
`endif
    drive();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rstn = 1;
    push_pkt(0, 3, 8'h00, 1);
    push_pkt(2, 2, 8'h00, 1);
    b = srcq[0][0];
    fd = b[DW-1:0];
    drive();
    cycle();
    chk("first_grant", grant, 4'b0001);
    cycle();
    chk("first_valid", m_tvalid, 1);
    chk("first_data", m_tdata, fd);
`ifdef AXIS_ARB_TID_EN
    chk("first_tid", m_tid, 0);
`endif
    run(200, c);
    do_reset();
    order.delete();
    n0 = nout;
    for (int i = 0; i < N; i++) push_pkt(i, 3, 8'hA0 + 8'(i), 0);
    push_pkt(0, 3, 8'hA0, 0);
    drive();
    run(200, c);
    chk("rot_cycles", c, 21);
    chk("rot_beats", nout - n0, 15);
    chk("rot_pkts", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) chk("rot_order", order[k], rot_exp[k]);
    push_pkt(1, 6, 8'h00, 1);
    drive();
    repeat (3) cycle();
    m_tready = 0;
    repeat (5) cycle();
    m_tready = 1;
    run(200, c);
    chk("bp_count", nout, nin);
    push_pkt(3, 5, 8'h00, 1);
    push_pkt(0, 2, 8'h00, 1);
    drive();
    repeat (3) cycle();
    stall[3] = 4;
    drive();
    repeat (4) begin
      cycle();
      chk("stall_grant", grant, 4'b1000);
      chk("stall_other_ready", s_tready[0], 0);
    end
    run(200, c);
    for (int p = 0; p < 6; p++) push_pkt(2, 1, 8'h00, 1);
    drive();
    run(200, c);
    chk("single_cycles", c, 13);
    for (int p = 0; p < 40; p++) push_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), 8'h00, 1);
    c = 0;
    while (pending() && c < 3000) begin
      m_tready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) stall[$urandom_range(0, N - 1)] = $urandom_range(1, 3);
      drive();
      cycle();
      c++;
    end
    chk("rand_bound", c < 3000, 1);
    m_tready = 1;
    run(200, c);
    chk("rand_count", nout, nin);
    do_reset();
    push_pkt(0, 4, 8'h00, 1);
    drive();
    cycle();
    cycle();
    rstn = 0;
    cycle();
    chk("rst_valid", m_tvalid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ready", s_tready, 0);
    for (int i = 0; i < N; i++) srcq[i].delete();
    rstn = 1;
    push_pkt(1, 2, 8'h00, 1);
    push_pkt(0, 2, 8'h00, 1);
    push_pkt(3, 1, 8'h00, 1);
    drive();
    cycle();
    chk("rst_first_grant", grant, 4'b0001);
    run(200, c);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin packet arbiter that shares one downstream AXI-Stream channel among N upstream stream sources. Grants are held for a whole packet, from the first accepted beat through the beat carrying `tlast`. The output is one registered stage that preserves full throughput inside a packet. It sits in front of the team's single-stage AXI-Stream register slices, so several producers can feed one consumer path.

## Interface
- `dw`, 8, data width per beat.
- `N`, 4, number of upstream sources; must be at least 2.
- `IW`, derived as `$clog2(N)`, width of the source index.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `s_tdata`  in  N*dw  source data, flattened; source i occupies bits [i*dw +: dw].
- `s_tvalid`  in  N  per-source valid.
- `s_tlast`  in  N  per-source end-of-packet marker.
- `s_tready`  out  N  per-source ready; at most one bit is set.
- `m_tdata`  out  dw  registered output data.
- `m_tvalid`  out  1  registered output valid.
- `m_tlast`  out  1  registered output last.
- `m_tready`  in  1  downstream ready.
- `grant`  out  N  one-hot current owner; zero in IDLE.
- `busy`  out  1  high while in state PASS.
- `m_tid`  out  IW  source index of the beat on `m_tdata`; present only with `AXIS_ARB_TID_EN`.

## Operation
- **States.**
  - IDLE: no owner; `grant` = 0; all `s_tready` = 0.
  - PASS: one source owns the output.
- **IDLE → PASS.**
  - Taken in the cycle any `s_tvalid` bit is high.
  - Winner is the first requesting index found scanning upward, with wrap, from `last+1`. `last` is the index of the previous owner.
  - The winner is registered into `grant`.
  - At reset `last` = N-1, so index 0 has top priority.
- **In PASS with owner g.**
  - `s_tready[g]` = `!m_tvalid || m_tready`. This is combinational from the output register state.
  - All other `s_tready` bits = 0.
- **Beat accept.** A beat is accepted when `s_tvalid[g] && s_tready[g]`. On accept, `s_tdata[g]` and `s_tlast[g]` are loaded into `m_tdata` and `m_tlast`, and `m_tvalid` is set to 1.
- **Downstream handshake.** When `m_tvalid && m_tready` and no new beat is accepted, `m_tvalid` → 0. `m_tdata` holds its value.
- **Packet end.** Accepting a beat with `s_tlast[g]` = 1 causes:
  - state → IDLE;
  - `last` ← g;
  - `grant` ← 0.
  The registered last beat then drains independently of the next arbitration.
- **Source stalls.** If `s_tvalid[g]` drops mid-packet, the grant is held indefinitely. Other sources wait.
- **Single-beat packets** (`tlast` on the first beat) are legal. Each one costs one IDLE cycle.
- **Fairness.** A sole requester may win consecutive packets. With several sources requesting, no source waits more than N-1 packets.
- **Reset mid-packet.** Every register returns to its reset value the next cycle. The partial packet is truncated, with no `tlast` emitted. Upstream must restart its packet.

## Timing
- **Reset values:**
  - `m_tdata` = 0
  - `m_tvalid` = 0
  - `m_tlast` = 0
  - `s_tready` = 0
  - `grant` = 0
  - `busy` = 0
  - `m_tid` = 0
  - state = IDLE
  - `last` = N-1
- **Grant latency.** `s_tvalid` seen in IDLE at cycle t → `grant` and `s_tready` are high at cycle t+1.
- **Data latency.** A beat accepted at cycle t appears on `m_tdata`/`m_tvalid` at t+1.
- **Throughput.** One beat per cycle within a packet while `m_tready` = 1. There is exactly one bubble cycle (IDLE) between the `tlast` accept and the first accept of the next packet.
- **Backpressure.** While `m_tvalid` = 1 and `m_tready` = 0:
  - `m_*` outputs are stable;
  - `s_tready[g]` = 0.
- **Simultaneous load and drain.** When `m_tready` = 1 and a new beat is accepted in the same cycle, `m_tvalid` stays 1 and `m_tdata` is replaced.
- **Output purity.** `m_*` outputs are registered only. `s_tready` is the sole combinational output.

## Configuration
- **`AXIS_ARB_TID_EN` defined:**
  - the `m_tid` port exists;
  - on each accepted beat it is loaded with g, alongside `m_tdata`;
  - it holds its value under backpressure and resets to 0.
- **`AXIS_ARB_TID_EN` undefined:** the `m_tid` port and its register are absent. All other behaviour is identical.

## Test plan
- **Reset and first grant.** Assert reset, then release; at cycle 0 raise `s_tvalid` = 4'b0101 with `m_tready` = 1. Required:
  - all outputs 0 during reset;
  - `grant` = 4'b0001 at cycle 1;
  - first beat of source 0 on `m_tdata` at cycle 2;
  - `m_tid` = 0 when `AXIS_ARB_TID_EN` is defined.
- **Round-robin rotation.** All four sources continuously send 3-beat packets with data 8'hA0+i. Required:
  - `m_tdata` packet order is source 0, 1, 2, 3, 0;
  - exactly one bubble between packets;
  - `m_tlast` set on every third beat.
- **Backpressure.** Hold `m_tready` = 0 for 5 cycles mid-packet. Required:
  - `m_tdata` and `m_tvalid` stable;
  - `s_tready[g]` = 0;
  - no beat lost or duplicated after release;
  - beat count out equals beat count in.
- **Source stall.** The owner drops `s_tvalid` for 4 cycles mid-packet while another source requests. Required:
  - `grant` unchanged;
  - the other source's `s_tready` = 0 until the owner's `tlast` is accepted.
- **Single-beat packets and sole requester.** Source 2 alone sends 1-beat packets back-to-back. Required:
  - source 2 is granted every packet;
  - one beat every 2 cycles on the output.
- **Reset mid-packet.** Pulse `rstn` = 0 for one cycle during the second beat. Required:
  - next cycle: `m_tvalid` = 0, `grant` = 0, `s_tready` = 0;
  - after release, source 0 wins first.
